// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_WMASK_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    GNT_IFU,
    GNT_LSU
  } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin picker: on a tie the requester that was not
// granted last wins. Grant bit 0 is IFU, bit 1 is LSU.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       valid_ifu_i,
  input  logic       valid_lsu_i,
  input  grant_e     last_grant_i,
  output logic [1:0] grant_o
);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_o = 2'b00;
    if (valid_ifu_i && valid_lsu_i) begin
      grant_o = (last_grant_i == GNT_IFU) ? 2'b10 : 2'b01;
    end else begin
      grant_o = {valid_lsu_i, valid_ifu_i};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU fetches and LSU loads/stores onto the single memory port and
// sequences each transaction as IDLE -> REQ -> WAIT -> RESP with a timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int WMASK_W        = DEF_WMASK_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [ADDR_W-1:0]  ifu_req_addr,
  output logic               ifu_resp_valid,
  output logic [DATA_W-1:0]  ifu_resp_rdata,
  output logic               ifu_resp_err,

  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic               lsu_req_wen,
  input  logic [ADDR_W-1:0]  lsu_req_addr,
  input  logic [DATA_W-1:0]  lsu_req_wdata,
  input  logic [WMASK_W-1:0] lsu_req_wmask,
  output logic               lsu_resp_valid,
  output logic [DATA_W-1:0]  lsu_resp_rdata,
  output logic               lsu_resp_err,

  output logic               mem_ld_wen,
  output logic               mem_st_wen,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [WMASK_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_rdata_ok,
  input  logic               mem_wdata_ok
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  grant_e             last_grant_q, last_grant_d;
  logic               store_q, store_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [WMASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ld_wen_q, st_wen_q;
  logic               ifu_rv_q, lsu_rv_q;

  logic [1:0] grant;
  logic       hs_ifu, hs_lsu, done;

  rr_arbiter2 u_rr (
    .valid_ifu_i  (ifu_req_valid),
    .valid_lsu_i  (lsu_req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Ready is the only combinational output; it is held low while reset is asserted.
  assign ifu_req_ready = !reset && (state_q == IDLE) && grant[0];
  assign lsu_req_ready = !reset && (state_q == IDLE) && grant[1];
  assign hs_ifu        = ifu_req_valid && ifu_req_ready;
  assign hs_lsu        = lsu_req_valid && lsu_req_ready;
  assign done          = store_q ? mem_wdata_ok : mem_rdata_ok;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    store_d      = store_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hs_ifu) begin
          last_grant_d = GNT_IFU;
          store_d      = 1'b0;
          addr_d       = ifu_req_addr;
          wdata_d      = '0;
          wmask_d      = '0;
          state_d      = REQ;
        end else if (hs_lsu) begin
          last_grant_d = GNT_LSU;
          store_d      = lsu_req_wen;
          addr_d       = lsu_req_addr;
          wdata_d      = lsu_req_wdata;
          wmask_d      = lsu_req_wmask;
          state_d      = REQ;
        end
      end
      REQ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done) begin
          rdata_d = store_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IFU;
      store_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      ld_wen_q     <= 1'b0;
      st_wen_q     <= 1'b0;
      ifu_rv_q     <= 1'b0;
      lsu_rv_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      store_q      <= store_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      // Strobes and response valids are registered from the next state.
      ld_wen_q     <= (state_d == REQ) && !store_d;
      st_wen_q     <= (state_d == REQ) && store_d;
      ifu_rv_q     <= (state_d == RESP) && (last_grant_d == GNT_IFU);
      lsu_rv_q     <= (state_d == RESP) && (last_grant_d == GNT_LSU);
    end
  end

  assign mem_ld_wen     = ld_wen_q;
  assign mem_st_wen     = st_wen_q;
  assign mem_raddr      = addr_q;
  assign mem_waddr      = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_rv_q;
  assign ifu_resp_rdata = rdata_q;
  assign ifu_resp_err   = err_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign lsu_resp_rdata = rdata_q;
  assign lsu_resp_err   = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single DPI load/store memory port. Instruction fetch (read-only) and LSU (load or store) present valid/ready requests. The block grants one at a time with round-robin fairness. It drives the one-cycle `*_wen` strobe to the memory port, waits for the registered `rdata_ok`/`wdata_ok` completion, and returns a one-cycle response to the granted requester. It sits between the IFU/LSU and the memory DPI port in the npc core.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `WMASK_W`, default 8: store byte-mask width, passed through unmodified.
- `TIMEOUT_CYCLES`, default 16: WAIT cycles without completion before an error response. Legal range is ≥1.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ifu_req_valid`  in  1 / `ifu_req_ready`  out  1 / `ifu_req_addr`  in  ADDR_W: fetch request.
- `ifu_resp_valid`  out  1 / `ifu_resp_rdata`  out  DATA_W / `ifu_resp_err`  out  1: fetch response.
- `lsu_req_valid`  in  1 / `lsu_req_ready`  out  1 / `lsu_req_wen`  in  1 (1 = store): LSU request handshake.
- `lsu_req_addr`  in  ADDR_W / `lsu_req_wdata`  in  DATA_W / `lsu_req_wmask`  in  WMASK_W: LSU request payload.
- `lsu_resp_valid`  out  1 / `lsu_resp_rdata`  out  DATA_W / `lsu_resp_err`  out  1: LSU response.
- `mem_ld_wen`, `mem_st_wen`  out  1: one-cycle memory strobes.
- `mem_raddr`, `mem_waddr`  out  ADDR_W / `mem_wdata`  out  DATA_W / `mem_wmask`  out  WMASK_W: memory request fields.
- `mem_rdata`  in  DATA_W / `mem_rdata_ok`, `mem_wdata_ok`  in  1: memory completion.

## Operation
- **States:** IDLE → REQ → WAIT → RESP → IDLE. State and `last_grant` are registered.
- **IDLE:**
  - Arbitrate among the valid requesters.
  - If only one is valid, that one wins.
  - If both are valid, the requester not equal to `last_grant` wins. `last_grant` resets to IFU, so the LSU wins the first tie.
  - `*_req_ready` is high only in IDLE, only for the winner; it is combinational from the valids.
  - On handshake: latch the payload (IFU forces load, wmask 0), record the grant, update `last_grant`, go to REQ.
- **Requester rule:** a requester holds valid and payload stable until ready. Dropping valid before ready is legal and is not a transaction.
- **REQ:**
  - For a load, assert `mem_ld_wen` for exactly this cycle with `mem_raddr` = latched address.
  - For a store, assert `mem_st_wen` with `mem_waddr`/`mem_wdata`/`mem_wmask`.
  - Go to WAIT and clear the timeout counter.
- **WAIT:**
  - A load completes on `mem_rdata_ok`; capture `mem_rdata` that cycle. A store completes on `mem_wdata_ok`. Either completion goes to RESP with err=0.
  - The ok of the wrong kind is ignored.
  - Otherwise increment the counter. After `TIMEOUT_CYCLES` WAIT cycles without completion, go to RESP with err=1 and rdata=0.
- **RESP:**
  - The granted requester's `resp_valid`=1 for one cycle, with latched rdata/err.
  - Store responses carry rdata=0.
  - No resp_ready: requesters must accept unconditionally.
  - Go to IDLE.
- **Idle outputs:** outside REQ, both `mem_*_wen`=0. Address and data outputs hold their latched values. Outside RESP, both `resp_valid`=0.
- **Stray completions:** `mem_*_ok` in IDLE, REQ or RESP is ignored.
- **Reset:**
  - Asynchronous: state→IDLE, `last_grant`→IFU, counter→0, all outputs and latches→0.
  - A transaction in flight is dropped with no response. A store already strobed may have committed.

## Timing
- **Nominal transaction:**
  - Handshake in C0.
  - `mem_*_wen` in C1.
  - Memory ok in C2.
  - `resp_valid` in C3.
  - Ready again in C4.
  - Request-to-response latency is 3 cycles; peak throughput is one transaction per 4 cycles.
- **Slow memory:** each extra cycle of memory delay adds one cycle. The latest successful completion is WAIT cycle `TIMEOUT_CYCLES`; the error response follows in the next cycle.
- **Back-to-back:** a new request pending during RESP is granted in the following IDLE cycle (C4). There is no grant during RESP.
- **Outputs:** all outputs except `*_req_ready` are registered.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum (IDLE/REQ/WAIT/RESP);
  - grant enum (GNT_IFU/GNT_LSU);
  - default `ADDR_W`/`DATA_W`/`WMASK_W` constants.
- Sub-module `rr_arbiter2`: combinational two-way round-robin picker. Inputs are two valids and `last_grant`; outputs are a one-hot grant.
- The FSM, payload latches and timeout counter (width `$clog2(TIMEOUT_CYCLES+1)`) stay in `mem_arbiter`.

## Test plan
- **IFU load alone:** IFU load at 0x8000_0000, memory returns 0x0000_0413 with 1-cycle ok → `mem_ld_wen` only in C1; `ifu_resp_valid` in C3 with 0x0000_0413, err=0; no LSU response.
- **LSU store:** addr 0x8000_1000, wdata 0xDEADBEEF, wmask 0x0F → single `mem_st_wen` pulse with those values; `lsu_resp_valid` in C3 with rdata=0, err=0.
- **Contention:** both requesters held valid for 4 transactions after reset → grants alternate LSU, IFU, LSU, IFU; each response goes only to its own requester.
- **Slow memory and timeout:** ok delayed 5 cycles → response at C3+4 with correct data; ok never asserted with TIMEOUT_CYCLES=16 → err=1, rdata=0, exactly 16 WAIT cycles after REQ.
- **Spurious completions:** `mem_wdata_ok` during a load, and ok pulses in IDLE → ignored; no response, state unchanged.
- **Reset during WAIT:** assert reset during WAIT of an LSU load → all outputs 0 immediately (asynchronous); no response after release; next request handshakes normally.
